// File: rtl/cios_pkg.sv
// Shared types for the CIOS Montgomery datapath: reduction-row FSM states and word typedefs.
package cios_pkg;

  localparam int unsigned CiosWidth = 32;

  typedef logic [CiosWidth-1:0]   word_t;
  typedef logic [2*CiosWidth-1:0] dword_t;

  typedef enum logic [2:0] {
    StIdle,
    StM,
    StMac,
    StFetch,
    StEmit,
    StTop0,
    StTop1,
    StDone
  } state_t;

endpackage

// File: rtl/cios_mac.sv
// Word cell t + m*n + c producing a double-width {carry, sum}; shared by multiply and reduce rows.
module cios_mac #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   t_i,
  input  logic [WIDTH-1:0]   m_i,
  input  logic [WIDTH-1:0]   n_i,
  input  logic [WIDTH-1:0]   c_i,
  output logic [2*WIDTH-1:0] sum_o
);

  localparam int unsigned DW = 2 * WIDTH;

  // Max value is (2^W-1)^2 + 2*(2^W-1) = 2^2W - 1, so DW bits never overflow.
  assign sum_o = DW'(m_i) * DW'(n_i) + DW'(t_i) + DW'(c_i);

endmodule

// File: rtl/cios_reduce.sv
// CIOS Montgomery reduction row: new T = (T + m*N) >> W, streamed one word per handshake.
// Optional zero check on the discarded low word enabled by defining CIOS_REDUCE_ZERO_CHECK_EN.
module cios_reduce import cios_pkg::*; #(
  parameter int unsigned WIDTH = CiosWidth,
  parameter int unsigned WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [WIDTH-1:0]         n0_inv_i,
  input  logic [WIDTH-1:0]         t_hi_i,
  input  logic [WIDTH-1:0]         t_hi1_i,
  input  logic                     t_valid_i,
  input  logic [WIDTH-1:0]         t_data_i,
  output logic                     t_ready_o,
  output logic                     n_rd_en_o,
  output logic [$clog2(WORDS)-1:0] n_addr_o,
  input  logic [WIDTH-1:0]         n_data_i,
  output logic                     out_valid_o,
  output logic [WIDTH-1:0]         out_data_o,
  output logic                     out_last_o,
  input  logic                     out_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int unsigned AW = $clog2(WORDS);
  localparam logic [AW-1:0] LastJ = AW'(WORDS - 1);

  state_t            state_q;
  logic [AW-1:0]     j_q;
  logic [WIDTH-1:0]  n0_inv_q, t_hi_q, t_hi1_q;
  logic [WIDTH-1:0]  c_q, m_q, t_q;
  logic              c1_q;
  logic              t_ready_q, out_valid_q, out_last_q, busy_q, done_q;
  logic [WIDTH-1:0]  out_data_q;

  logic [2*WIDTH-1:0] mac_sum;
  logic [WIDTH-1:0]   m_word;
  logic [WIDTH:0]     top0_sum;

  cios_mac #(
    .WIDTH(WIDTH)
  ) u_mac (
    .t_i  (t_q),
    .m_i  (m_q),
    .n_i  (n_data_i),
    .c_i  (c_q),
    .sum_o(mac_sum)
  );

  assign m_word   = t_data_i * n0_inv_q;
  assign top0_sum = {1'b0, t_hi_q} + {1'b0, c_q};

  // The modulus read goes out in the T-handshake cycle so N[j] arrives in the following MAC cycle.
  assign n_rd_en_o   = t_ready_q & t_valid_i;
  assign n_addr_o    = j_q;
  assign t_ready_o   = t_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      j_q         <= '0;
      n0_inv_q    <= '0;
      t_hi_q      <= '0;
      t_hi1_q     <= '0;
      c_q         <= '0;
      c1_q        <= 1'b0;
      m_q         <= '0;
      t_q         <= '0;
      t_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            n0_inv_q  <= n0_inv_i;
            t_hi_q    <= t_hi_i;
            t_hi1_q   <= t_hi1_i;
            c_q       <= '0;
            j_q       <= '0;
            t_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StM;
          end
        end
        StM: begin
          if (t_valid_i) begin
            m_q       <= m_word;
            t_q       <= t_data_i;
            t_ready_q <= 1'b0;
            state_q   <= StMac;
          end
        end
        StMac: begin
          c_q <= mac_sum[2*WIDTH-1:WIDTH];
          if (j_q == '0) begin
            j_q       <= j_q + AW'(1);
            t_ready_q <= 1'b1;
            state_q   <= StFetch;
          end else begin
            out_valid_q <= 1'b1;
            out_data_q  <= mac_sum[WIDTH-1:0];
            state_q     <= StEmit;
          end
        end
        StFetch: begin
          if (t_valid_i) begin
            t_q       <= t_data_i;
            t_ready_q <= 1'b0;
            state_q   <= StMac;
          end
        end
        StEmit: begin
          if (out_ready_i) begin
            if (j_q != LastJ) begin
              out_valid_q <= 1'b0;
              j_q         <= j_q + AW'(1);
              t_ready_q   <= 1'b1;
              state_q     <= StFetch;
            end else begin
              // out_valid stays high: the T[s] word follows with no bubble.
              out_data_q <= top0_sum[WIDTH-1:0];
              c1_q       <= top0_sum[WIDTH];
              state_q    <= StTop0;
            end
          end
        end
        StTop0: begin
          if (out_ready_i) begin
            out_data_q <= t_hi1_q + {{(WIDTH-1){1'b0}}, c1_q};
            out_last_q <= 1'b1;
            state_q    <= StTop1;
          end
        end
        StTop1: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CIOS_REDUCE_ZERO_CHECK_EN
  logic err_q;

  // A correct n0_inv always zeroes the discarded low word of the j=0 MAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == StIdle && start_i) begin
      err_q <= 1'b0;
    end else if (state_q == StMac && j_q == '0 && mac_sum[WIDTH-1:0] != '0) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cios_reduce.sv
// Bench for cios_reduce (WIDTH=8, WORDS=2) against an integer model of (T + m*N) >> W.
module tb_cios_reduce;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] n0_inv, t_hi, t_hi1, t_data, n_data, out_data;
  logic       t_valid, t_ready, n_rd_en, out_valid, out_last, out_ready, busy, done, err;
  logic [0:0] n_addr;
  logic [7:0] nmem [2];

  int nvec = 0;
  int nerr = 0;

`ifdef CIOS_REDUCE_ZERO_CHECK_EN
  localparam bit ZeroCheck = 1'b1;
`else
  localparam bit ZeroCheck = 1'b0;
`endif

  always #5 clk = ~clk;

  cios_reduce #(
    .WIDTH(8),
    .WORDS(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .n0_inv_i   (n0_inv),
    .t_hi_i     (t_hi),
    .t_hi1_i    (t_hi1),
    .t_valid_i  (t_valid),
    .t_data_i   (t_data),
    .t_ready_o  (t_ready),
    .n_rd_en_o  (n_rd_en),
    .n_addr_o   (n_addr),
    .n_data_i   (n_data),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .out_ready_i(out_ready),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  // Synchronous modulus memory with one cycle of read latency.
  always @(posedge clk) if (n_rd_en) n_data <= nmem[n_addr];

  // Integer model: new T words k=0..2 of floor((T + m*N) / 2^8), plus the low-word zero check.
  function automatic logic [24:0] model(input logic [7:0] t0, t1, thi, thi1, ninv);
    longint tt, nn, m, r;
    logic   bad;
    tt  = longint'(t0) + (longint'(t1) << 8) + (longint'(thi) << 16) + (longint'(thi1) << 24);
    nn  = longint'(nmem[0]) + (longint'(nmem[1]) << 8);
    m   = (longint'(t0) * longint'(ninv)) % 256;
    r   = (tt + m * nn) >> 8;
    bad = ((longint'(t0) + m * longint'(nmem[0])) % 256) != 0;
    return {bad & ZeroCheck, r[23:0]};
  endfunction

  function automatic logic [7:0] inv_neg(input logic [7:0] n0);
    for (int x = 0; x < 256; x++) if (((int'(n0) * x) % 256) == 255) return 8'(x);
    return 8'h00;
  endfunction

  // Runs one row and returns what the DUT produced; callers do the comparisons.
  task automatic do_row(input logic [7:0] t0, t1, thi, thi1, ninv, input bit bp,
                        input int hold, input bit restart,
                        output logic [23:0] got, output logic [2:0] lastv, output int nout,
                        output int gap, output int viol, output logic err_v, output bit tmo);
    int ti, lastcyc, hold_left;
    logic [7:0] held;
    bit stall;
    got = '0; lastv = '0; nout = 0; gap = -1; viol = 0; err_v = 1'b0; tmo = 1'b1;
    ti = 0; lastcyc = 0; hold_left = hold; held = '0;
    @(negedge clk);
    start = 1'b1; n0_inv = ninv; t_hi = thi; t_hi1 = thi1;
    @(negedge clk);
    for (int cyc = 0; cyc < 200; cyc++) begin
      t_valid   = (ti < 2) && (!bp || $urandom_range(3) != 0);
      t_data    = (ti == 0) ? t0 : t1;
      out_ready = !bp || $urandom_range(1) == 1;
      if (restart && cyc == 2) begin
        start = 1'b1; n0_inv = ~ninv; t_hi = ~thi;
      end else begin
        start = 1'b0; n0_inv = ninv; t_hi = thi;
      end
      stall = 1'b0;
      if (out_valid && hold_left > 0) begin
        if (hold_left == hold) held = out_data;
        out_ready = 1'b0; stall = 1'b1; hold_left--;
      end
      #1;
      if (out_valid && t_ready) viol++;
      if (stall && (out_data !== held || t_ready !== 1'b0 || n_rd_en !== 1'b0)) viol++;
      if (t_ready && t_valid) ti++;
      if (out_valid && out_ready) begin
        if (nout < 3) begin
          got[nout*8 +: 8] = out_data;
          lastv[nout]      = out_last;
        end
        nout++;
        lastcyc = cyc;
      end
      if (done) begin
        gap = cyc - lastcyc; err_v = err; tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0; t_valid = 1'b0; out_ready = 1'b0;
    if (!tmo) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) viol++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; t_valid = 1'b0; out_ready = 1'b0;
    n0_inv = '0; t_hi = '0; t_hi1 = '0; t_data = '0;
    repeat (3) @(negedge clk);
    #1;
    nvec++; if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL reset busy/done: got %b%b want 00", busy, done);
    end
    nvec++; if (t_ready !== 1'b0 || n_rd_en !== 1'b0 || n_addr !== 1'b0) begin
      nerr++; $display("FAIL reset t_ready/n_rd_en/n_addr: got %b%b%b want 000",
                       t_ready, n_rd_en, n_addr);
    end
    nvec++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin
      nerr++; $display("FAIL reset out: got v%b l%b d%h want v0 l0 d00",
                       out_valid, out_last, out_data);
    end
    nvec++; if (err !== 1'b0) begin
      nerr++; $display("FAIL reset err: got %b want 0", err);
    end
    rst = 1'b0;
  endtask

  task automatic test_known_vectors();
    logic [7:0]  tab_n1 [2] = '{8'h00, 8'hFF};
    logic [7:0]  tab_t0 [2] = '{8'h01, 8'hFF};
    logic [7:0]  tab_t1 [2] = '{8'h00, 8'hFF};
    logic [7:0]  tab_hi [2] = '{8'h00, 8'hFF};
    logic [23:0] tab_ex [2] = '{24'h0000E1, 24'h0110FF};
    logic [23:0] got; logic [2:0] lastv; int nout, gap, viol; logic err_v; bit tmo;
    for (int i = 0; i < 2; i++) begin
      nmem[0] = 8'hF1; nmem[1] = tab_n1[i];
      do_row(tab_t0[i], tab_t1[i], tab_hi[i], 8'h00, 8'hEF, 1'b0, 0, 1'b0,
             got, lastv, nout, gap, viol, err_v, tmo);
      nvec++; if (tmo || got !== tab_ex[i] || nout != 3) begin
        nerr++; $display("FAIL known%0d words: got %h n%0d tmo%0b want %h n3",
                         i, got, nout, tmo, tab_ex[i]);
      end
      nvec++; if (lastv !== 3'b100 || gap != 1) begin
        nerr++; $display("FAIL known%0d last/done: got last %b gap %0d want 100 gap 1",
                         i, lastv, gap);
      end
      nvec++; if (viol != 0 || err_v !== 1'b0) begin
        nerr++; $display("FAIL known%0d protocol/err: got viol %0d err %b want 0 0",
                         i, viol, err_v);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] got; logic [2:0] lastv; int nout, gap, viol; logic err_v; bit tmo;
    nmem[0] = 8'hF1; nmem[1] = 8'h00;
    do_row(8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 1'b0, 5, 1'b0,
           got, lastv, nout, gap, viol, err_v, tmo);
    nvec++; if (tmo || got !== 24'h0000E1 || lastv !== 3'b100) begin
      nerr++; $display("FAIL stall words: got %h last %b tmo%0b want 0000e1 last 100",
                       got, lastv, tmo);
    end
    nvec++; if (viol != 0) begin
      nerr++; $display("FAIL stall hold: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_abort();
    logic [23:0] got; logic [2:0] lastv; int nout, gap, viol; logic err_v; bit tmo;
    int ti;
    bit seen;
    nmem[0] = 8'hF1; nmem[1] = 8'h00;
    ti = 0; seen = 1'b0;
    @(negedge clk);
    start = 1'b1; n0_inv = 8'hEF; t_hi = 8'h00; t_hi1 = 8'h00; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      t_valid = (ti < 2); t_data = (ti == 0) ? 8'h01 : 8'h00;
      #1;
      if (t_ready && t_valid) ti++;
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    nvec++; if (!seen) begin
      nerr++; $display("FAIL abort reach-emit: got no out_valid want out_valid");
    end
    @(negedge clk);
    rst = 1'b1; t_valid = 1'b0;
    @(negedge clk);
    #1;
    nvec++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || t_ready !== 1'b0) begin
      nerr++; $display("FAIL abort state: got busy%b v%b d%h rdy%b want 0 0 00 0",
                       busy, out_valid, out_data, t_ready);
    end
    rst = 1'b0;
    do_row(8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 1'b0, 0, 1'b0,
           got, lastv, nout, gap, viol, err_v, tmo);
    nvec++; if (tmo || got !== 24'h0000E1 || lastv !== 3'b100 || gap != 1 || viol != 0) begin
      nerr++; $display("FAIL abort rerun: got %h last %b gap %0d viol %0d want 0000e1 100 1 0",
                       got, lastv, gap, viol);
    end
  endtask

  task automatic test_zero_check();
    logic [23:0] got; logic [2:0] lastv; int nout, gap, viol; logic err_v; bit tmo;
    logic [24:0] exp;
    nmem[0] = 8'hF1; nmem[1] = 8'h00;
    exp = model(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    do_row(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0,
           got, lastv, nout, gap, viol, err_v, tmo);
    nvec++; if (tmo || err_v !== exp[24]) begin
      nerr++; $display("FAIL zchk err: got %b tmo%0b want %b", err_v, tmo, exp[24]);
    end
    nvec++; if (got !== exp[23:0] || lastv !== 3'b100 || gap != 1) begin
      nerr++; $display("FAIL zchk row: got %h last %b gap %0d want %h 100 1",
                       got, lastv, gap, exp[23:0]);
    end
    // A following good row must clear the sticky flag at start.
    do_row(8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 1'b0, 0, 1'b0,
           got, lastv, nout, gap, viol, err_v, tmo);
    nvec++; if (tmo || err_v !== 1'b0 || got !== 24'h0000E1) begin
      nerr++; $display("FAIL zchk clear: got err %b words %h want 0 0000e1", err_v, got);
    end
  endtask

  task automatic test_start_ignore();
    logic [23:0] got; logic [2:0] lastv; int nout, gap, viol; logic err_v; bit tmo;
    nmem[0] = 8'hF1; nmem[1] = 8'h00;
    do_row(8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 1'b0, 0, 1'b1,
           got, lastv, nout, gap, viol, err_v, tmo);
    nvec++; if (tmo || got !== 24'h0000E1 || nout != 3 || viol != 0) begin
      nerr++; $display("FAIL restart busy: got %h n%0d viol %0d want 0000e1 n3 viol 0",
                       got, nout, viol);
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    nvec++; if (busy !== 1'b0 || t_ready !== 1'b0) begin
      nerr++; $display("FAIL start+rst: got busy%b rdy%b want 0 0", busy, t_ready);
    end
    @(negedge clk);
    #1;
    nvec++; if (busy !== 1'b0) begin
      nerr++; $display("FAIL start+rst later: got busy %b want 0", busy);
    end
  endtask

  task automatic test_random();
    logic [23:0] got; logic [2:0] lastv; int nout, gap, viol; logic err_v; bit tmo;
    logic [7:0] t0, t1, thi, thi1, ninv;
    logic [24:0] exp;
    for (int r = 0; r < 24; r++) begin
      nmem[0] = 8'($urandom) | 8'h01; nmem[1] = 8'($urandom);
      t0 = 8'($urandom); t1 = 8'($urandom); thi = 8'($urandom);
      thi1 = 8'($urandom_range(1));
      ninv = ($urandom_range(3) == 0) ? 8'($urandom) : inv_neg(nmem[0]);
      exp = model(t0, t1, thi, thi1, ninv);
      do_row(t0, t1, thi, thi1, ninv, r[0], 0, 1'b0, got, lastv, nout, gap, viol, err_v, tmo);
      nvec++; if (tmo || got !== exp[23:0] || nout != 3) begin
        nerr++; $display("FAIL rand%0d words: got %h n%0d tmo%0b want %h n3",
                         r, got, nout, tmo, exp[23:0]);
      end
      nvec++; if (lastv !== 3'b100 || gap != 1 || viol != 0 || err_v !== exp[24]) begin
        nerr++; $display("FAIL rand%0d ctl: got last %b gap %0d viol %0d err %b want 100 1 0 %b",
                         r, lastv, gap, viol, err_v, exp[24]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_abort();
    test_zero_check();
    test_start_ignore();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
